// File: rtl/tdc_launch_gen_if.sv
// Control/status bundle between launch-generator firmware side and tdc_launch_gen.
// Firmware (master) drives run controls; generator (slave) returns launch outputs.
interface tdc_launch_gen_if #(
  parameter int DIV_W   = 4,
  parameter int BURST_W = 8,
  parameter int CNT_W   = 16
);
  // Controls are levels sampled on each clk_launch rising edge; there is no
  // valid/ready pairing, and start is honoured only while busy is low.
  logic               start;
  logic               stop;
  logic               burst_mode;
  logic [DIV_W-1:0]   div;
  logic [BURST_W-1:0] burst_len;
  logic               pg_tog;
  logic               launch_stb;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   launch_cnt;
  logic [1:0]         state_dbg;

  modport master (
    output start, stop, burst_mode, div, burst_len,
    input  pg_tog, launch_stb, busy, done, launch_cnt, state_dbg
  );

  modport slave (
    input  start, stop, burst_mode, div, burst_len,
    output pg_tog, launch_stb, busy, done, launch_cnt, state_dbg
  );
endinterface

// File: rtl/tdc_launch_gen.sv
// Launch toggle generator for the TDC: programmable half-period, burst/continuous runs.
// Optional return-to-zero on run exit is enabled by defining TDC_LAUNCH_RTZ_EN.
module tdc_launch_gen #(
  parameter int DIV_W   = 4,
  parameter int BURST_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic clk_launch,
  input  logic rst_n,
  tdc_launch_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
`ifdef TDC_LAUNCH_RTZ_EN
    S_RTZ  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic               mode_q, mode_d;
  logic [DIV_W-1:0]   hc_q, hc_d;
  logic [BURST_W-1:0] tc_q, tc_d;
  logic               pg_tog_q, pg_tog_d;
  logic               stb_q, stb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               tog_due;
  logic [DIV_W-1:0]   hc_inc;
  logic [BURST_W-1:0] tc_inc;
  logic [CNT_W-1:0]   cnt_inc;

  assign tog_due = (hc_q == div_q);
  assign hc_inc  = hc_q + DIV_W'(1);
  assign tc_inc  = tc_q + BURST_W'(1);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    len_d    = len_q;
    mode_d   = mode_q;
    hc_d     = hc_q;
    tc_d     = tc_q;
    pg_tog_d = pg_tog_q;
    stb_d    = 1'b0;
    done_d   = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          div_d  = bus.div;
          len_d  = bus.burst_len;
          mode_d = bus.burst_mode;
          hc_d   = '0;
          tc_d   = '0;
          cnt_d  = '0;
          if (bus.burst_mode && (bus.burst_len == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (tog_due) begin
          pg_tog_d = ~pg_tog_q;
          stb_d    = 1'b1;
          hc_d     = '0;
          tc_d     = tc_inc;
          cnt_d    = cnt_inc;
        end else begin
          hc_d = hc_inc;
        end
        // A due toggle is still issued on the exit edge, whether stop or burst end.
        if (bus.stop || (tog_due && mode_q && (tc_inc == len_q))) begin
`ifdef TDC_LAUNCH_RTZ_EN
          if (pg_tog_d) begin
            state_d = S_RTZ;
            hc_d    = '0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end
      end

`ifdef TDC_LAUNCH_RTZ_EN
      S_RTZ: begin
        if (tog_due) begin
          pg_tog_d = 1'b0;
          stb_d    = 1'b1;
          cnt_d    = cnt_inc;
          state_d  = S_DONE;
          done_d   = 1'b1;
        end else begin
          hc_d = hc_inc;
        end
      end
`endif

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_launch) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      hc_q     <= '0;
      tc_q     <= '0;
      pg_tog_q <= 1'b0;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      hc_q     <= hc_d;
      tc_q     <= tc_d;
      pg_tog_q <= pg_tog_d;
      stb_q    <= stb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.pg_tog     = pg_tog_q;
  assign bus.launch_stb = stb_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.launch_cnt = cnt_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_tdc_launch_gen.sv
// Directed bench for tdc_launch_gen: continuous, burst, zero-length burst, stop and reset cases.
module tb_tdc_launch_gen;
  localparam int DIV_W   = 4;
  localparam int BURST_W = 8;
  localparam int CNT_W   = 16;

  logic clk_launch;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;
  logic exp_pg;

  tdc_launch_gen_if #(.DIV_W(DIV_W), .BURST_W(BURST_W), .CNT_W(CNT_W)) bus ();

  tdc_launch_gen #(.DIV_W(DIV_W), .BURST_W(BURST_W), .CNT_W(CNT_W)) dut (
    .clk_launch (clk_launch),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  // clock / reset
  initial clk_launch = 1'b0;
  always #5 clk_launch = ~clk_launch;

  task automatic step();
    @(posedge clk_launch);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic pg, input logic stb,
                            input logic bsy, input logic dn, input int cnt);
    check({tag, ".pg_tog"},     32'(bus.pg_tog),     32'(pg));
    check({tag, ".launch_stb"}, 32'(bus.launch_stb), 32'(stb));
    check({tag, ".busy"},       32'(bus.busy),       32'(bsy));
    check({tag, ".done"},       32'(bus.done),       32'(dn));
    check({tag, ".launch_cnt"}, 32'(bus.launch_cnt), 32'(cnt));
  endtask

  task automatic drive_idle();
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.burst_mode = 1'b0;
    bus.div        = '0;
    bus.burst_len  = '0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    drive_idle();
    rst_n = 1'b0;
    step();
    step();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("reset.state", 32'(bus.state_dbg), 32'd0);
    rst_n = 1'b1;
    step();
    exp_pg = 1'b0;

    // continuous div=1, with ignored div/start changes mid-run, then stop
    bus.div = 4'd1; bus.burst_mode = 1'b0; bus.start = 1'b1;
    step();
    check_outs("cont.accept", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    bus.start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin bus.div = 4'd7; bus.start = 1'b1; end
      if (i == 6) bus.start = 1'b0;
      step();
      check_outs($sformatf("cont.e%0d", i), exp_pg ^ (((i / 2) % 2) == 1),
                 (i % 2) == 0, 1'b1, 1'b0, i / 2);
    end
    bus.stop = 1'b1;
    step();
    check_outs("cont.stop", 1'b0, 1'b0, 1'b1, 1'b1, 4);
    bus.stop = 1'b0;
    step();
    check_outs("cont.idle", 1'b0, 1'b0, 1'b0, 1'b0, 4);

    // burst of 5 at div=0
    bus.div = 4'd0; bus.burst_mode = 1'b1; bus.burst_len = 8'd5; bus.start = 1'b1;
    step();
    check_outs("burst.accept", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    bus.start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
`ifdef TDC_LAUNCH_RTZ_EN
      check_outs($sformatf("burst.e%0d", i), (i % 2) == 1, 1'b1, 1'b1, 1'b0, i);
`else
      check_outs($sformatf("burst.e%0d", i), (i % 2) == 1, 1'b1, 1'b1, i == 5, i);
`endif
    end
`ifdef TDC_LAUNCH_RTZ_EN
    step();
    check_outs("burst.rtz", 1'b0, 1'b1, 1'b1, 1'b1, 6);
    step();
    check_outs("burst.end", 1'b0, 1'b0, 1'b0, 1'b0, 6);
    exp_pg = 1'b0;
`else
    step();
    check_outs("burst.end", 1'b1, 1'b0, 1'b0, 1'b0, 5);
    exp_pg = 1'b1;
`endif

    // zero-length burst
    bus.burst_len = 8'd0; bus.start = 1'b1;
    step();
    check_outs("zero.done", exp_pg, 1'b0, 1'b1, 1'b1, 0);
    check("zero.state", 32'(bus.state_dbg), 32'd3);
    bus.start = 1'b0;
    step();
    check_outs("zero.idle", exp_pg, 1'b0, 1'b0, 1'b0, 0);

    // continuous div=3, stop coincides with the second due toggle
    bus.div = 4'd3; bus.burst_mode = 1'b0; bus.start = 1'b1;
    step();
    check_outs("stop.accept", exp_pg, 1'b0, 1'b1, 1'b0, 0);
    bus.start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) bus.stop = 1'b1;
      step();
      check_outs($sformatf("stop.e%0d", i), exp_pg ^ (i >= 4 && i < 8),
                 (i % 4) == 0, 1'b1, i == 8, i / 4);
    end
    bus.stop = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      check_outs($sformatf("stop.after%0d", j), exp_pg, 1'b0, 1'b0, 1'b0, 2);
    end

    // reset in the middle of a 10-toggle burst
    bus.div = 4'd0; bus.burst_mode = 1'b1; bus.burst_len = 8'd10; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("rstmid.cnt%0d", i), 32'(bus.launch_cnt), 32'(i));
    end
    rst_n = 1'b0;
    step();
    check_outs("rstmid.reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    step();
    check_outs("rstmid.after", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
